// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD widths, frame-checker state encoding and the BCD
//               digit validity rule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  // Digits 10..15 all have bit 3 set together with bit 2 or bit 1.
  function automatic logic is_bad_bcd(input logic [BCD_W-1:0] d);
    return d[3] & (d[2] | d[1]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_check.sv
// ============================================================================
// Module      : bcd_digit_check
// Description : Flags a non-BCD digit and supplies the digit to be stored.
//               Build macro BCD_CORRECT_EN saturates invalid digits to 9.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_d,
  output logic             o_bad,
  output logic [BCD_W-1:0] o_fixed
);

  assign o_bad = is_bad_bcd(i_d);

`ifdef BCD_CORRECT_EN
  assign o_fixed = o_bad ? BCD_MAX : i_d;
`else
  assign o_fixed = i_d;
`endif

endmodule

`default_nettype wire

// File: rtl/bcd_frame_checker.sv
// ============================================================================
// Module      : bcd_frame_checker
// Description : Collects DIGITS BCD digits MS-first, validates each one and
//               holds the packed frame plus error summary until taken.
//               Build macro BCD_CORRECT_EN stores invalid digits as 9.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_frame_checker
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2,
  parameter int CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [BCD_W-1:0]        i_in_digit,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [BCD_W*DIGITS-1:0] o_out_word,
  output logic                    o_out_err,
  output logic [IDX_W-1:0]        o_out_err_idx,
  output logic [CNT_W-1:0]        o_out_err_cnt
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_cnt;
  logic [BCD_W*DIGITS-1:0]   r_word;
  logic                      r_err;
  logic [IDX_W-1:0]          r_err_idx;
  logic [CNT_W-1:0]          r_err_cnt;

  logic                      w_accept;
  logic                      w_last;
  logic                      w_bad;
  logic [BCD_W-1:0]          w_fixed;

  bcd_digit_check u_digit_check (
    .i_d     (i_in_digit),
    .o_bad   (w_bad),
    .o_fixed (w_fixed)
  );

  assign o_in_ready  = (r_state == ST_COLLECT);
  assign o_out_valid = (r_state == ST_HOLD);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last      = (r_cnt == C_LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_accept && w_last) w_state_nxt = ST_HOLD;
      ST_HOLD:    if (i_out_ready)        w_state_nxt = ST_COLLECT;
      default:                            w_state_nxt = ST_COLLECT;
    endcase
    // Flush wins over both the input accept and the output handshake.
    if (i_flush) w_state_nxt = ST_COLLECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_word    <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_err_cnt <= '0;
    end else if (i_flush || (o_out_valid && i_out_ready)) begin
      r_cnt     <= '0;
      r_word    <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      r_word <= {r_word[BCD_W*(DIGITS-1)-1:0], w_fixed};
      r_cnt  <= w_last ? '0 : r_cnt + IDX_W'(1);
      if (w_bad) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (!r_err) begin
          r_err     <= 1'b1;
          r_err_idx <= r_cnt;
        end
      end
    end
  end

  assign o_out_word    = r_word;
  assign o_out_err     = r_err;
  assign o_out_err_idx = r_err_idx;
  assign o_out_err_cnt = r_err_cnt;

endmodule

`default_nettype wire
